// File: rtl/mem_access_unit_if.sv
// M-stage request / W-stage response bundle for mem_access_unit.
// master drives the M side and observes W; slave is the unit itself.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ValidM;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic                  MemReadM;
  logic [1:0]            ResultSrcM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [4:0]            RdM;
  logic [DATA_WIDTH-1:0] PCPlus4M;
  logic [2:0]            StoreSrcM;
  logic [2:0]            LoadSrcM;
  logic                  StallM;
  logic                  ValidW;
  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [4:0]            RdW;
  logic [DATA_WIDTH-1:0] ALUResultW;
  logic [DATA_WIDTH-1:0] ReadDataW;
  logic [DATA_WIDTH-1:0] PCPlus4W;
  logic                  FaultW;

  modport master (
    output ValidM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, ALUResultM,
           WriteDataM, RdM, PCPlus4M, StoreSrcM, LoadSrcM,
    input  StallM, ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW,
           ReadDataW, PCPlus4W, FaultW
  );

  modport slave (
    input  ValidM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, ALUResultM,
           WriteDataM, RdM, PCPlus4M, StoreSrcM, LoadSrcM,
    output StallM, ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW,
           ReadDataW, PCPlus4W, FaultW
  );
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: byte-lane data memory with sized/aligned loads and
// stores, fault reporting, and a stall FSM for multi-cycle load latency.
module mem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(NB);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit LONG     = (MEM_LATENCY > 1);
  localparam logic [1:0] CNT_INIT = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [OFF_BITS-1:0]   off;
  logic [1:0]            size;
  logic [2:0]            amask;
  logic                  store_legal;
  logic                  load_legal;
  logic                  misaligned;
  logic                  fault;
  logic                  accept;
  logic                  do_store;
  logic                  long_load;
  logic [NB-1:0]         be_base;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [DATA_WIDTH-1:0] load_data;

  // Request held while a long-latency load is in flight
  logic [ADDR_WIDTH-1:0] pend_idx;
  logic [OFF_BITS-1:0]   pend_off;
  logic [2:0]            pend_src;
  logic                  pend_regwrite;
  logic [1:0]            pend_resultsrc;
  logic [4:0]            pend_rd;
  logic [DATA_WIDTH-1:0] pend_alu;
  logic [DATA_WIDTH-1:0] pend_pc;

  function automatic logic [DATA_WIDTH-1:0] extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [OFF_BITS-1:0]   o,
    input logic [2:0]            src
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sgn;
    sh = word >> {o, 3'b000};
    case (src[1:0])
      2'd0:    begin mask = DATA_WIDTH'(8'hFF);         sgn = sh[7];  end
      2'd1:    begin mask = DATA_WIDTH'(16'hFFFF);      sgn = sh[15]; end
      2'd2:    begin mask = DATA_WIDTH'(32'hFFFF_FFFF); sgn = sh[31]; end
      default: begin mask = '1;                         sgn = 1'b0;   end
    endcase
    sgn = sgn & ~src[2];
    return sgn ? (sh | ~mask) : (sh & mask);
  endfunction

  assign idx    = bus.ALUResultM[ADDR_WIDTH+OFF_BITS-1:OFF_BITS];
  assign off    = bus.ALUResultM[OFF_BITS-1:0];
  assign accept = bus.ValidM && (state == IDLE);

  always_comb begin
    size        = bus.MemWriteM ? bus.StoreSrcM[1:0] : bus.LoadSrcM[1:0];
    store_legal = !bus.StoreSrcM[2] && ((bus.StoreSrcM[1:0] != 2'b11) || (DATA_WIDTH == 64));
    load_legal  = (bus.LoadSrcM != 3'b111) &&
                  (((bus.LoadSrcM[1:0] != 2'b11) && (bus.LoadSrcM != 3'b110)) || (DATA_WIDTH == 64));
    case (size)
      2'd0:    begin amask = 3'b000; be_base = NB'(1);     end
      2'd1:    begin amask = 3'b001; be_base = NB'(3);     end
      2'd2:    begin amask = 3'b011; be_base = NB'(4'hF);  end
      default: begin amask = 3'b111; be_base = '1;         end
    endcase
    misaligned = |(bus.ALUResultM[2:0] & amask);
    fault      = (bus.MemWriteM || bus.MemReadM) &&
                 ((bus.MemWriteM && bus.MemReadM) ||
                  (bus.MemWriteM && !store_legal) ||
                  (bus.MemReadM && !load_legal) ||
                  misaligned);
  end

  assign be         = be_base << off;
  assign wdata_lane = bus.WriteDataM << {off, 3'b000};
  assign do_store   = accept && bus.MemWriteM && !fault;
  assign long_load  = LONG && bus.MemReadM && !fault;

  // While BUSY no new request is accepted, so no store can race the pending read
  assign load_data = (state == BUSY) ? extract(mem[pend_idx], pend_off, pend_src)
                                     : extract(mem[idx], off, bus.LoadSrcM);

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      bus.StallM     <= 1'b0;
      bus.ValidW     <= 1'b0;
      bus.RegWriteW  <= 1'b0;
      bus.ResultSrcW <= 2'd0;
      bus.RdW        <= 5'd0;
      bus.ALUResultW <= '0;
      bus.ReadDataW  <= '0;
      bus.PCPlus4W   <= '0;
      bus.FaultW     <= 1'b0;
      pend_idx       <= '0;
      pend_off       <= '0;
      pend_src       <= 3'd0;
      pend_regwrite  <= 1'b0;
      pend_resultsrc <= 2'd0;
      pend_rd        <= 5'd0;
      pend_alu       <= '0;
      pend_pc        <= '0;
    end else begin
      bus.ValidW    <= 1'b0;
      bus.RegWriteW <= 1'b0;
      bus.FaultW    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (long_load) begin
              state          <= BUSY;
              cnt            <= CNT_INIT;
              bus.StallM     <= 1'b1;
              bus.ResultSrcW <= 2'd0;
              bus.RdW        <= 5'd0;
              pend_idx       <= idx;
              pend_off       <= off;
              pend_src       <= bus.LoadSrcM;
              pend_regwrite  <= bus.RegWriteM;
              pend_resultsrc <= bus.ResultSrcM;
              pend_rd        <= bus.RdM;
              pend_alu       <= bus.ALUResultM;
              pend_pc        <= bus.PCPlus4M;
            end else begin
              bus.ValidW     <= 1'b1;
              bus.RegWriteW  <= bus.RegWriteM && !fault;
              bus.FaultW     <= fault;
              bus.ResultSrcW <= bus.ResultSrcM;
              bus.RdW        <= bus.RdM;
              bus.ALUResultW <= bus.ALUResultM;
              bus.PCPlus4W   <= bus.PCPlus4M;
              if (fault)             bus.ReadDataW <= '0;
              else if (bus.MemReadM) bus.ReadDataW <= load_data;
            end
          end
        end
        BUSY: begin
          if (cnt == 2'd0) begin
            state          <= IDLE;
            bus.StallM     <= 1'b0;
            bus.ValidW     <= 1'b1;
            bus.RegWriteW  <= pend_regwrite;
            bus.ResultSrcW <= pend_resultsrc;
            bus.RdW        <= pend_rd;
            bus.ALUResultW <= pend_alu;
            bus.PCPlus4W   <= pend_pc;
            bus.ReadDataW  <= load_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: four instances (32-bit base, 3-cycle
// latency, 4-bit word address, 64-bit) share one stimulus payload.
module tb_mem_access_unit;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SD = 3'd3;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
  localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;
  localparam logic [3:0] A = 4'b0001, L = 4'b0010, WR = 4'b0100, D = 4'b1000;

  logic        clk;
  logic        rst;
  logic [3:0]  v_m;
  logic        rw_m, mw_m, mr_m;
  logic [1:0]  rs_m;
  logic [2:0]  src_m;
  logic [4:0]  rd_m;
  logic [63:0] addr_m, wd_m, pc_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_access_unit_if #(.DATA_WIDTH(32)) if_a ();
  mem_access_unit_if #(.DATA_WIDTH(32)) if_l ();
  mem_access_unit_if #(.DATA_WIDTH(32)) if_w ();
  mem_access_unit_if #(.DATA_WIDTH(64)) if_d ();

  assign if_a.ValidM = v_m[0]; assign if_l.ValidM = v_m[1];
  assign if_w.ValidM = v_m[2]; assign if_d.ValidM = v_m[3];
  assign if_a.RegWriteM = rw_m; assign if_a.MemWriteM = mw_m; assign if_a.MemReadM = mr_m;
  assign if_l.RegWriteM = rw_m; assign if_l.MemWriteM = mw_m; assign if_l.MemReadM = mr_m;
  assign if_w.RegWriteM = rw_m; assign if_w.MemWriteM = mw_m; assign if_w.MemReadM = mr_m;
  assign if_d.RegWriteM = rw_m; assign if_d.MemWriteM = mw_m; assign if_d.MemReadM = mr_m;
  assign if_a.ResultSrcM = rs_m; assign if_a.RdM = rd_m; assign if_a.StoreSrcM = src_m; assign if_a.LoadSrcM = src_m;
  assign if_l.ResultSrcM = rs_m; assign if_l.RdM = rd_m; assign if_l.StoreSrcM = src_m; assign if_l.LoadSrcM = src_m;
  assign if_w.ResultSrcM = rs_m; assign if_w.RdM = rd_m; assign if_w.StoreSrcM = src_m; assign if_w.LoadSrcM = src_m;
  assign if_d.ResultSrcM = rs_m; assign if_d.RdM = rd_m; assign if_d.StoreSrcM = src_m; assign if_d.LoadSrcM = src_m;
  assign if_a.ALUResultM = addr_m[31:0]; assign if_a.WriteDataM = wd_m[31:0]; assign if_a.PCPlus4M = pc_m[31:0];
  assign if_l.ALUResultM = addr_m[31:0]; assign if_l.WriteDataM = wd_m[31:0]; assign if_l.PCPlus4M = pc_m[31:0];
  assign if_w.ALUResultM = addr_m[31:0]; assign if_w.WriteDataM = wd_m[31:0]; assign if_w.PCPlus4M = pc_m[31:0];
  assign if_d.ALUResultM = addr_m;       assign if_d.WriteDataM = wd_m;       assign if_d.PCPlus4M = pc_m;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(3)) u_l (.clk(clk), .rst(rst), .bus(if_l));
  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_LATENCY(1)) u_w (.clk(clk), .rst(rst), .bus(if_w));
  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .MEM_LATENCY(1)) u_d (.clk(clk), .rst(rst), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at the falling edge; returns 1 time unit after the capturing edge
  task automatic issue(input logic [3:0] sel, input logic mw, input logic mr, input logic rw,
                       input logic [2:0] src, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [4:0] rd);
    @(negedge clk);
    v_m = sel; mw_m = mw; mr_m = mr; rw_m = rw; src_m = src;
    addr_m = addr; wd_m = wd; rd_m = rd; pc_m = addr + 64'd4; rs_m = 2'b10;
    $display("[TB] sel=%b mw=%0b mr=%0b src=%0d addr=0x%0h wdata=0x%0h rd=%0d",
             sel, mw, mr, src, addr, wd, rd);
    @(posedge clk);
    #1 v_m = 4'b0000;
  endtask

  task automatic st(input logic [3:0] sel, input logic [2:0] src, input logic [63:0] addr,
                    input logic [63:0] wd);
    issue(sel, 1'b1, 1'b0, 1'b0, src, addr, wd, 5'd0);
  endtask

  task automatic ld(input logic [3:0] sel, input logic [2:0] src, input logic [63:0] addr,
                    input logic [4:0] rd);
    issue(sel, 1'b0, 1'b1, 1'b1, src, addr, 64'd0, rd);
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v_m = 4'b0; rw_m = 0; mw_m = 0; mr_m = 0; rs_m = 0;
    src_m = 0; rd_m = 0; addr_m = 0; wd_m = 0; pc_m = 0;
    #1;
    chk("rst_a_stall", if_a.StallM, 0);
    chk("rst_a_validw", if_a.ValidW, 0);
    chk("rst_a_readdata", if_a.ReadDataW, 0);
    chk("rst_a_fault", if_a.FaultW, 0);
    chk("rst_l_stall", if_l.StallM, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Base instance: sized loads/stores, sign/zero extension, faults
    st(A, SW, 64'h10, 64'hDEADBEEF);
    chk("sw_valid", if_a.ValidW, 1);
    chk("sw_fault", if_a.FaultW, 0);
    chk("sw_regwrite", if_a.RegWriteW, 0);
    ld(A, LB, 64'h13, 5'd5);
    chk("lb_data", if_a.ReadDataW, 64'hFFFFFFDE);
    chk("lb_regwrite", if_a.RegWriteW, 1);
    chk("lb_rd", if_a.RdW, 5);
    ld(A, LBU, 64'h13, 5'd6);
    chk("lbu_data", if_a.ReadDataW, 64'h000000DE);
    ld(A, LH, 64'h12, 5'd7);
    chk("lh_data", if_a.ReadDataW, 64'hFFFFDEAD);
    ld(A, LHU, 64'h10, 5'd8);
    chk("lhu_data", if_a.ReadDataW, 64'h0000BEEF);
    st(A, SW, 64'h20, 64'hAAAAAAAA);
    st(A, SH, 64'h22, 64'hFFFF1234);
    ld(A, LW, 64'h20, 5'd9);
    chk("sh_merge", if_a.ReadDataW, 64'h1234AAAA);
    ld(A, LW, 64'h21, 5'd10);
    chk("lw_mis_fault", if_a.FaultW, 1);
    chk("lw_mis_regwrite", if_a.RegWriteW, 0);
    chk("lw_mis_data", if_a.ReadDataW, 0);
    chk("lw_mis_valid", if_a.ValidW, 1);
    st(A, SW, 64'h22, 64'h55555555);
    chk("sw_mis_fault", if_a.FaultW, 1);
    issue(A, 1'b1, 1'b1, 1'b1, LW, 64'h20, 64'h66666666, 5'd11);
    chk("rdwr_fault", if_a.FaultW, 1);
    issue(A, 1'b0, 1'b1, 1'b1, LD, 64'h20, 64'd0, 5'd12);
    chk("ld32_fault", if_a.FaultW, 1);
    issue(A, 1'b1, 1'b0, 1'b0, SD, 64'h20, 64'h77777777, 5'd0);
    chk("sd32_fault", if_a.FaultW, 1);
    ld(A, LW, 64'h20, 5'd13);
    chk("no_write_on_fault", if_a.ReadDataW, 64'h1234AAAA);
    st(A, SB, 64'h21, 64'h12345677);
    ld(A, LW, 64'h20, 5'd14);
    chk("sb_merge", if_a.ReadDataW, 64'h123477AA);
    tick();
    chk("idle_valid", if_a.ValidW, 0);
    chk("idle_regwrite", if_a.RegWriteW, 0);
    chk("idle_hold_data", if_a.ReadDataW, 64'h123477AA);
    issue(A, 1'b0, 1'b0, 1'b1, SB, 64'h99, 64'd0, 5'd7);
    chk("alu_result", if_a.ALUResultW, 64'h99);
    chk("alu_pc", if_a.PCPlus4W, 64'h9D);
    chk("alu_resultsrc", if_a.ResultSrcW, 2);
    chk("alu_regwrite", if_a.RegWriteW, 1);
    chk("alu_fault", if_a.FaultW, 0);

    // Latency-3 instance: two stall cycles, stalled input ignored
    st(L, SW, 64'h08, 64'hCAFEF00D);
    chk("lat_sw_stall", if_l.StallM, 0);
    chk("lat_sw_valid", if_l.ValidW, 1);
    ld(L, LW, 64'h08, 5'd3);
    chk("lat_c1_stall", if_l.StallM, 1);
    chk("lat_c1_valid", if_l.ValidW, 0);
    st(L, SW, 64'h08, 64'h11111111);
    chk("lat_c2_stall", if_l.StallM, 1);
    chk("lat_c2_valid", if_l.ValidW, 0);
    tick();
    chk("lat_c3_stall", if_l.StallM, 0);
    chk("lat_c3_valid", if_l.ValidW, 1);
    chk("lat_c3_data", if_l.ReadDataW, 64'hCAFEF00D);
    chk("lat_c3_rd", if_l.RdW, 3);
    ld(L, LW, 64'h09, 5'd4);
    chk("lat_mis_stall", if_l.StallM, 0);
    chk("lat_mis_fault", if_l.FaultW, 1);

    // Narrow address instance: word index wraps
    st(WR, SW, 64'h40, 64'h0BADCAFE);
    ld(WR, LW, 64'h00, 5'd1);
    chk("wrap_00", if_w.ReadDataW, 64'h0BADCAFE);
    ld(WR, LW, 64'h80, 5'd1);
    chk("wrap_80", if_w.ReadDataW, 64'h0BADCAFE);

    // 64-bit instance: double-word and word lanes
    st(D, SD, 64'h18, 64'h0123456789ABCDEF);
    ld(D, LD, 64'h18, 5'd2);
    chk("d_ld", if_d.ReadDataW, 64'h0123456789ABCDEF);
    ld(D, LW, 64'h18, 5'd2);
    chk("d_lw_lo", if_d.ReadDataW, 64'hFFFFFFFF89ABCDEF);
    ld(D, LWU, 64'h18, 5'd2);
    chk("d_lwu", if_d.ReadDataW, 64'h0000000089ABCDEF);
    ld(D, LW, 64'h1C, 5'd2);
    chk("d_lw_hi", if_d.ReadDataW, 64'h0000000001234567);
    ld(D, LB, 64'h1F, 5'd2);
    chk("d_lb_top", if_d.ReadDataW, 64'h01);
    st(D, SD, 64'h1C, 64'h1);
    chk("d_sd_mis", if_d.FaultW, 1);
    st(D, SW, 64'h1C, 64'hFFFFFFFF00C0FFEE);
    ld(D, LD, 64'h18, 5'd2);
    chk("d_sw_hi", if_d.ReadDataW, 64'h00C0FFEE89ABCDEF);

    // Reset in the middle of a long load
    ld(L, LW, 64'h08, 5'd9);
    chk("abort_pre_stall", if_l.StallM, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_stall", if_l.StallM, 0);
    chk("abort_valid", if_l.ValidW, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_wb", if_l.ValidW, 0);
    end
    ld(A, LW, 64'h10, 5'd1);
    chk("mem_survives_rst", if_a.ReadDataW, 64'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
